// File: rtl/decodificador_pwm_servo.sv
// Servo PWM receiver: measures the high time of each PWM period and decodes it
// back to the 3-bit posicao code, flagging out-of-tolerance pulses and signal loss.
module decodificador_pwm_servo #(
  parameter int unsigned conf_periodo = 1000000,
  parameter int unsigned largura_000  = 35000,
  parameter int unsigned largura_001  = 45700,
  parameter int unsigned largura_010  = 56450,
  parameter int unsigned largura_011  = 67150,
  parameter int unsigned largura_100  = 77850,
  parameter int unsigned largura_101  = 88550,
  parameter int unsigned largura_110  = 99300,
  parameter int unsigned largura_111  = 110000,
  parameter int unsigned tolerancia   = 2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pwm,
  output logic [2:0]  posicao,
  output logic [20:0] largura_medida,
  output logic        pronto,
  output logic        erro,
  output logic        sem_sinal
);

  // estado         | meaning
  // ESPERA_SUBIDA  | idle, waiting for a rising edge on the synced input
  // MEDE_ALTO      | counting high cycles until the falling edge
  // ESPERA_DESCIDA | stuck-high already reported, waiting for the fall
  typedef enum logic [1:0] {ESPERA_SUBIDA, MEDE_ALTO, ESPERA_DESCIDA} estado_t;

  localparam logic [20:0] periodo = 21'(conf_periodo);
  localparam logic [20:0] tol     = 21'(tolerancia);
  localparam logic [21:0] limite  = 22'(2 * conf_periodo + 1);
  localparam logic [20:0] nominal [8] = '{
    21'(largura_000), 21'(largura_001), 21'(largura_010), 21'(largura_011),
    21'(largura_100), 21'(largura_101), 21'(largura_110), 21'(largura_111)
  };

  estado_t     estado;
  logic        sinc1, sinc2, sinc_ant;
  logic [2:0]  valido;
  logic [20:0] cont_largura;
  logic [21:0] cont_silencio;
  logic [20:0] largura_cap;
  logic        captura;
  logic        subida, descida;
  logic [2:0]  melhor;
  logic [20:0] dist_min;

  function automatic logic [20:0] distancia(input logic [20:0] a, input logic [20:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Edges only count once the delayed copy holds a real post-reset sample, so a
  // pin that is already high when reset releases does not look like a rise.
  assign subida  = valido[2] &  sinc2 & ~sinc_ant;
  assign descida = valido[2] & ~sinc2 &  sinc_ant;

  always_comb begin
    melhor   = 3'd0;
    dist_min = distancia(largura_cap, nominal[0]);
    for (int k = 1; k < 8; k++) begin
      if (distancia(largura_cap, nominal[k]) < dist_min) begin
        melhor   = 3'(k);
        dist_min = distancia(largura_cap, nominal[k]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado         <= ESPERA_SUBIDA;
      sinc1          <= 1'b0;
      sinc2          <= 1'b0;
      sinc_ant       <= 1'b0;
      valido         <= 3'b000;
      cont_largura   <= '0;
      cont_silencio  <= '0;
      largura_cap    <= '0;
      captura        <= 1'b0;
      posicao        <= 3'b000;
      largura_medida <= '0;
      pronto         <= 1'b0;
      erro           <= 1'b0;
      sem_sinal      <= 1'b1;
    end else begin
      sinc1    <= pwm;
      sinc2    <= sinc1;
      sinc_ant <= sinc2;
      valido   <= {valido[1:0], 1'b1};
      pronto   <= 1'b0;
      erro     <= 1'b0;
      captura  <= 1'b0;

      if (subida || descida) begin
        cont_silencio <= '0;
      end else if (cont_silencio != limite) begin
        cont_silencio <= cont_silencio + 22'd1;
      end
      if (cont_silencio == limite) begin
        sem_sinal <= 1'b1;
      end

      case (estado)
        ESPERA_SUBIDA: begin
          if (subida) begin
            cont_largura <= 21'd1;
            estado       <= MEDE_ALTO;
          end
        end
        MEDE_ALTO: begin
          if (descida) begin
            largura_cap <= cont_largura;
            captura     <= 1'b1;
            estado      <= ESPERA_SUBIDA;
          end else if (cont_largura == periodo) begin
            pronto         <= 1'b1;
            erro           <= 1'b1;
            largura_medida <= periodo;
            estado         <= ESPERA_DESCIDA;
          end else begin
            cont_largura <= cont_largura + 21'd1;
          end
        end
        ESPERA_DESCIDA: begin
          if (descida) begin
            estado <= ESPERA_SUBIDA;
          end
        end
        default: estado <= ESPERA_SUBIDA;
      endcase

      // Decode happens one cycle after the fall so the comparator tree sees a stable width.
      if (captura) begin
        pronto         <= 1'b1;
        largura_medida <= largura_cap;
        if (dist_min <= tol) begin
          posicao   <= melhor;
          sem_sinal <= 1'b0;
        end else begin
          erro <= 1'b1;
        end
      end
    end
  end

endmodule
